// File: rtl/fifo_rd_drain.sv
// Read-side FIFO consumer: issues pops against a credit limit, absorbs the fixed
// read latency in a small prefetch buffer and presents a valid/ready stream.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | not fetching, nothing buffered or in flight
// ST_RUN   | fetching from the FIFO while en=1
// ST_DRAIN | en dropped; delivering buffered/in-flight words, no new pops
module fifo_rd_drain #(
   parameter int DATA_W     = 11,
   parameter int RD_LATENCY = 1,
   parameter int CNT_W      = 16
) (
   input  logic              rd_clk,
   input  logic              rst,
   input  logic              en,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_rd_en,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  word_count,
   output logic [1:0]        state,
   output logic              idle
);

   localparam int BUF_DEPTH = RD_LATENCY + 1;
   localparam int PTR_W     = (BUF_DEPTH > 2) ? $clog2(BUF_DEPTH) : 1;
   localparam int OCC_W     = 3;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
   localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(BUF_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_DRAIN = 2'b10
   } state_t;

   state_t cur_state, nxt_state;

   logic [DATA_W-1:0]     mem [BUF_DEPTH];
   logic [PTR_W-1:0]      head, tail;
   logic [OCC_W-1:0]      occ, occ_nxt, infl_cnt;
   logic [RD_LATENCY-1:0] infl, infl_nxt;
   logic                  pop, arrival, credit_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign out_valid = (occ != '0);
   assign out_data  = mem[head];
   assign pop       = out_valid & out_ready;
   assign arrival   = infl[RD_LATENCY-1];
   assign idle      = (occ == '0) && (infl == '0);
   assign state     = cur_state;

   always_comb begin
      infl_cnt = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         infl_cnt = infl_cnt + OCC_W'(infl[i]);
      end
   end

   // Counting in-flight words as already occupied guarantees every return has a slot.
   assign credit_ok  = ((occ + infl_cnt - OCC_W'(pop)) < DEPTH_C);
   assign fifo_rd_en = (cur_state == ST_RUN) & en & ~fifo_empty & credit_ok;

   always_comb begin
      infl_nxt    = '0;
      infl_nxt[0] = fifo_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) begin
         infl_nxt[i] = infl[i-1];
      end
      occ_nxt = occ + OCC_W'(arrival) - OCC_W'(pop);
   end

   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         ST_IDLE: begin
            if (en) nxt_state = ST_RUN;
         end
         ST_RUN: begin
            if (!en) nxt_state = ((occ != '0) || (infl != '0)) ? ST_DRAIN : ST_IDLE;
         end
         ST_DRAIN: begin
            if (en)                                        nxt_state = ST_RUN;
            else if ((occ_nxt == '0) && (infl_nxt == '0))  nxt_state = ST_IDLE;
         end
         default: nxt_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge rd_clk) begin
      if (rst) begin
         cur_state  <= ST_IDLE;
         occ        <= '0;
         infl       <= '0;
         head       <= '0;
         tail       <= '0;
         word_count <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         cur_state <= nxt_state;
         occ       <= occ_nxt;
         infl      <= infl_nxt;
         if (arrival) begin
            mem[tail] <= fifo_data;
            tail      <= ptr_inc(tail);
         end
         if (pop) begin
            head       <= ptr_inc(head);
            word_count <= word_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: two instances (latency 1 / 16-bit count, latency 2 / 4-bit count)
// driven by shared stimulus, each with its own FIFO model and word-level scoreboard.
module tb_fifo_rd_drain;

   localparam int DW = 11;

   logic clk = 1'b0;
   logic rst, en, out_ready;
   logic [1:0]      fe_v;
   logic [DW-1:0]   fd [2];
   logic [1:0]      rd_v, ov_v, idle_v;
   logic [2*DW-1:0] od_v;
   logic [31:0]     wc_v;
   logic [3:0]      st_v;

   initial forever #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 1 : 2;
      localparam int CWG = (g == 0) ? 16 : 4;
      logic [CWG-1:0] wc;
      logic [DW-1:0]  od;
      logic [1:0]     st;
      logic           rd, ov, idl;
      fifo_rd_drain #(.DATA_W(DW), .RD_LATENCY(LAT), .CNT_W(CWG)) u_dut (
         .rd_clk(clk), .rst(rst), .en(en), .fifo_empty(fe_v[g]), .fifo_data(fd[g]),
         .fifo_rd_en(rd), .out_data(od), .out_valid(ov), .out_ready(out_ready),
         .word_count(wc), .state(st), .idle(idl));
      assign rd_v[g]            = rd;
      assign ov_v[g]            = ov;
      assign idle_v[g]          = idl;
      assign od_v[g*DW +: DW]   = od;
      assign wc_v[g*16 +: 16]   = 16'(wc);
      assign st_v[g*2 +: 2]     = st;
   end

   typedef struct {
      logic [DW-1:0] v;
      int            t;
   } ent_t;

   logic [DW-1:0] fq [2][$];
   ent_t          expq [2][$];
   logic [DW-1:0] dp [2][2];
   int   wc_m [2], st_m [2], dl [2];
   int   edge_k;
   logic prev_rd [2], prev_hs [2];
   logic prev_en, prev_rst;
   logic en_s, ready_s, rst_s, tog, blk;
   int   pops [2], rd_run [2], rd_max [2], v_run [2], v_max [2], first_rd [2], first_v [2];
   logic [DW-1:0] first_d [2];
   int   n_cmp, n_fail;
   int   d0, d1, budget;

   function automatic int lat(input int i);
      return (i == 0) ? 1 : 2;
   endfunction

   function automatic int cmask(input int i);
      return (i == 0) ? 32'hFFFF : 32'hF;
   endfunction

   function automatic logic [DW-1:0] od(input int i);
      return od_v[i*DW +: DW];
   endfunction

   task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] want);
      n_cmp++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s inst%0d t=%0t got=%0h expected=%0h", name, i, $time, act, want);
      end
   endtask

   task automatic clr_obs();
      for (int i = 0; i < 2; i++) begin
         pops[i] = 0; rd_run[i] = 0; rd_max[i] = 0; v_run[i] = 0; v_max[i] = 0;
         first_rd[i] = -1; first_v[i] = -1; first_d[i] = '0;
      end
   endtask

   task automatic load(input int n, input int base);
      for (int j = 0; j < n; j++) begin
         fq[0].push_back(DW'(base + j));
         fq[1].push_back(DW'(base + j));
      end
   endtask

   // One clock: account for the edge that just happened, apply inputs, then check.
   task automatic cycle();
      @(negedge clk);
      edge_k++;
      blk = ~blk;
      for (int i = 0; i < 2; i++) begin
         int pend;
         logic [DW-1:0] v;
         ent_t e;
         pend = expq[i].size();
         v = DW'($urandom);
         if (prev_rd[i] && fq[i].size() > 0) v = fq[i].pop_front();
         dp[i][1] = dp[i][0];
         dp[i][0] = v;
         fd[i] = dp[i][lat(i)-1];
         if (prev_rst) begin
            expq[i].delete();
            wc_m[i] = 0;
            st_m[i] = 0;
         end else begin
            if (prev_hs[i]) begin
               void'(expq[i].pop_front());
               wc_m[i]++;
               dl[i]++;
            end
            if (prev_rd[i]) begin
               e.v = v;
               e.t = edge_k;
               expq[i].push_back(e);
            end
            case (st_m[i])
               0: if (prev_en) st_m[i] = 1;
               1: if (!prev_en) st_m[i] = (pend != 0) ? 2 : 0;
               default: begin
                  if (prev_en) st_m[i] = 1;
                  else if (expq[i].size() == 0) st_m[i] = 0;
               end
            endcase
         end
         fe_v[i] = (fq[i].size() == 0) || (tog && blk);
      end
      en = en_s;
      out_ready = ready_s;
      rst = rst_s;
      #1;
      for (int i = 0; i < 2; i++) begin
         int sz;
         bit ev, exp_rd;
         sz = expq[i].size();
         ev = (sz > 0) && (edge_k - expq[i][0].t >= lat(i));
         chk("out_valid", i, ov_v[i], ev);
         if (ev) chk("out_data", i, od(i), expq[i][0].v);
         chk("word_count", i, wc_v[i*16 +: 16], wc_m[i] & cmask(i));
         chk("idle", i, idle_v[i], sz == 0);
         chk("state", i, st_v[i*2 +: 2], st_m[i]);
         exp_rd = (st_m[i] == 1) && en_s && !fe_v[i] && ((sz - int'(ev && ready_s)) < lat(i) + 1);
         chk("fifo_rd_en", i, rd_v[i], exp_rd);
         if (fe_v[i]) chk("pop_on_empty", i, rd_v[i], 0);
         if (rd_v[i]) begin
            pops[i]++;
            rd_run[i]++;
            if (first_rd[i] < 0) first_rd[i] = edge_k;
         end else rd_run[i] = 0;
         if (rd_run[i] > rd_max[i]) rd_max[i] = rd_run[i];
         if (ov_v[i]) begin
            v_run[i]++;
            if (first_v[i] < 0) begin
               first_v[i] = edge_k;
               first_d[i] = od(i);
            end
         end else v_run[i] = 0;
         if (v_run[i] > v_max[i]) v_max[i] = v_run[i];
         prev_rd[i] = rd_v[i];
         prev_hs[i] = ev && ready_s;
      end
      prev_en = en_s;
      prev_rst = rst_s;
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   initial begin
      n_cmp = 0; n_fail = 0; edge_k = 0;
      rst = 1'b1; en = 1'b0; out_ready = 1'b0; fe_v = 2'b11;
      rst_s = 1'b1; en_s = 1'b0; ready_s = 1'b0; tog = 1'b0; blk = 1'b0;
      prev_en = 1'b0; prev_rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         fd[i] = '0; dp[i][0] = '0; dp[i][1] = '0;
         wc_m[i] = 0; st_m[i] = 0; dl[i] = 0; prev_rd[i] = 1'b0; prev_hs[i] = 1'b0;
      end
      clr_obs();

      // reset state
      run(2);
      for (int i = 0; i < 2; i++) begin
         chk("rst_valid", i, ov_v[i], 0);
         chk("rst_data", i, od(i), 0);
         chk("rst_rd_en", i, rd_v[i], 0);
         chk("rst_idle", i, idle_v[i], 1);
         chk("rst_count", i, wc_v[i*16 +: 16], 0);
         chk("rst_state", i, st_v[i*2 +: 2], 0);
      end

      // preload 1..8, full throughput
      rst_s = 1'b0; ready_s = 1'b1;
      load(8, 1);
      run(2);
      clr_obs();
      en_s = 1'b1;
      run(15);
      chk("s1_rd_run", 0, rd_max[0], 8);
      chk("s1_rd_run", 1, rd_max[1], 8);
      chk("s1_valid_run", 0, v_max[0], 8);
      chk("s1_valid_run", 1, v_max[1], 8);
      chk("s1_latency", 0, first_v[0] - first_rd[0], 2);
      chk("s1_latency", 1, first_v[1] - first_rd[1], 3);
      chk("s1_first_data", 0, first_d[0], 11'h001);
      chk("s1_count", 0, wc_v[15:0], 8);
      chk("s1_idle", 0, idle_v[0], 1);
      chk("s1_state", 0, st_v[1:0], 2'b01);

      // back-pressure: only BUF_DEPTH pops while ready is low
      ready_s = 1'b0;
      load(8, 1);
      clr_obs();
      run(10);
      chk("s2_pops_held", 0, pops[0], 2);
      chk("s2_pops_held", 1, pops[1], 3);
      chk("s2_hold_valid", 0, ov_v[0], 1);
      chk("s2_hold_data", 0, od(0), 11'h001);
      chk("s2_hold_data", 1, od(1), 11'h001);
      ready_s = 1'b1;
      run(15);
      chk("s2_pops_total", 0, pops[0], 8);
      chk("s2_count", 0, wc_v[15:0], 16);
      chk("s2_count_wrap", 1, wc_v[31:16], 0);

      // empty toggling, random ready, 200 words
      tog = 1'b1;
      d0 = dl[0]; d1 = dl[1];
      load(200, 12'h100);
      budget = 0;
      while (((dl[0] - d0) < 200 || (dl[1] - d1) < 200) && budget < 3000) begin
         ready_s = 1'($urandom_range(0, 1));
         cycle();
         budget++;
      end
      chk("s3_words", 0, dl[0] - d0, 200);
      chk("s3_words", 1, dl[1] - d1, 200);
      tog = 1'b0;
      ready_s = 1'b1;
      run(3);

      // drop en with words pending
      ready_s = 1'b0;
      load(4, 12'h020);
      run(5);
      en_s = 1'b0;
      clr_obs();
      d0 = dl[0]; d1 = dl[1];
      run(2);
      chk("s4_drain", 0, st_v[1:0], 2'b10);
      chk("s4_drain", 1, st_v[3:2], 2'b10);
      ready_s = 1'b1;
      run(6);
      chk("s4_no_pops", 0, pops[0], 0);
      chk("s4_no_pops", 1, pops[1], 0);
      chk("s4_delivered", 0, dl[0] - d0, 2);
      chk("s4_delivered", 1, dl[1] - d1, 3);
      chk("s4_idle_state", 0, st_v[1:0], 2'b00);
      chk("s4_idle", 0, idle_v[0], 1);
      clr_obs();
      en_s = 1'b1;
      run(8);
      chk("s4_resume_state", 0, st_v[1:0], 2'b01);
      chk("s4_resume_pops", 0, pops[0], 2);
      chk("s4_resume_pops", 1, pops[1], 1);

      // reset with one buffered and one in-flight word
      ready_s = 1'b0;
      load(3, 12'h040);
      run(2);
      rst_s = 1'b1;
      cycle();
      rst_s = 1'b0;
      cycle();
      for (int i = 0; i < 2; i++) begin
         chk("s5_valid", i, ov_v[i], 0);
         chk("s5_count", i, wc_v[i*16 +: 16], 0);
         chk("s5_state", i, st_v[i*2 +: 2], 0);
      end
      cycle();
      chk("s5_late_return", 0, ov_v[0], 0);
      chk("s5_late_return", 1, ov_v[1], 0);
      ready_s = 1'b1;
      run(8);

      // 17 words: 4-bit counter wraps to 1
      rst_s = 1'b1;
      cycle();
      rst_s = 1'b0;
      load(17, 12'h050);
      run(30);
      chk("s6_count", 0, wc_v[15:0], 17);
      chk("s6_count_wrap", 1, wc_v[31:16], 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_rd_drain.md
Name: fifo_rd_drain

Overview:
Read-side consumer for the dual-clock FIFO. It runs entirely in the read clock domain. It issues pops to the FIFO read port (empty flag, registered memory output with fixed read latency) and hides that latency behind a small prefetch buffer. The result is a valid/ready stream for downstream logic at up to one word per cycle. It also provides enable/drain control and a delivered-word counter.

Parameters:
DATA_W, 11, word width; matches FIFO data path
RD_LATENCY, 1, cycles from fifo_rd_en high to fifo_data valid; legal values 1 or 2
CNT_W, 16, width of delivered-word counter

Ports:
rd_clk  in  1  read-domain clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  1 = fetch from FIFO; 0 = stop issuing pops, drain what is already fetched
fifo_empty  in  1  FIFO empty flag, rd_clk domain
fifo_data  in  DATA_W  FIFO memory output, valid RD_LATENCY cycles after a pop
fifo_rd_en  out  1  pop strobe to FIFO
out_data  out  DATA_W  head word of prefetch buffer
out_valid  out  1  out_data holds a word
out_ready  in  1  downstream accepts when out_valid & out_ready
word_count  out  CNT_W  number of completed output handshakes, wraps modulo 2^CNT_W
state  out  2  00 IDLE, 01 RUN, 10 DRAIN
idle  out  1  no buffered and no in-flight words

Behaviour:
- Reset (rst=1 at an edge):
  - occupancy = 0, in-flight = 0, state = IDLE, word_count = 0.
  - out_valid = 0, out_data = 0, fifo_rd_en = 0, idle = 1.
  - In-flight returns are discarded. Words already popped from the FIFO are lost by design.
- Buffer:
  - BUF_DEPTH = RD_LATENCY+1 entries, circular, registered storage.
  - out_data = head entry; out_valid = (occupancy != 0).
- In-flight tracking: shift register of RD_LATENCY bits. The bit set at issue time arrives RD_LATENCY edges later; on that edge, fifo_data is written to the buffer tail.
- pop = out_valid & out_ready.
- fifo_rd_en (combinational) = (state==RUN) & en & !fifo_empty & (occupancy + inflight_count - pop < BUF_DEPTH).
  - Combinational path out_ready -> fifo_rd_en is intentional. It gives full throughput: one word/cycle sustained with out_ready held 1.
- Occupancy next = occupancy + arrival - pop. Simultaneous arrival and pop keeps occupancy unchanged. The buffer never overflows, because the credit check guarantees it.
- Output hold: out_data and out_valid stay stable while out_valid & !out_ready.
- Never pops when fifo_empty=1. A pop on an empty FIFO is a bug; the bench asserts it never happens.
- FSM (evaluated every edge, rst overrides):
  - IDLE: en=1 -> RUN.
  - RUN: en=0 and (occupancy|inflight)!=0 -> DRAIN; en=0 and nothing pending -> IDLE.
  - DRAIN: en=1 -> RUN; all pending delivered (idle next) -> IDLE.
  - Pops are issued only in RUN, and only while en=1 in the same cycle.
- word_count increments on each pop and wraps from 2^CNT_W-1 to 0.
- idle = (occupancy==0) & (inflight_count==0), combinational.
- Latency: word visible on out_data/out_valid RD_LATENCY+1 edges after the edge where the FIFO goes non-empty with en=1, or RD_LATENCY edges after the fifo_rd_en edge.

Test Plan:
- Reset, en=1, FIFO preloaded 0x001..0x008, out_ready=1, RD_LATENCY=1 -> fifo_rd_en high 8 consecutive cycles. out_valid high 8 consecutive cycles, first one cycle after first pop, data 0x001..0x008 in order. word_count=8, then idle=1, state RUN.
- Same preload, out_ready=0 for 10 cycles -> exactly 2 pops (BUF_DEPTH). out_valid=1 and out_data=0x001 held stable. Release ready -> remaining words delivered in order with no loss or duplicate.
- FIFO toggling empty every other cycle, out_ready random 50% -> never fifo_rd_en while fifo_empty. Output sequence equals input sequence, with 200 words checked by scoreboard.
- en dropped while 2 words pending -> state DRAIN, no further fifo_rd_en, both words delivered, then state IDLE and idle=1. en reasserted -> RUN and fetching resumes.
- rst asserted with 1 buffered and 1 in-flight word -> next cycle out_valid=0, word_count=0, state IDLE, and the late fifo_data return is not captured.
- CNT_W=4, deliver 17 words -> word_count wraps 15->0, final value 1. Repeat the first scenario with RD_LATENCY=2 -> BUF_DEPTH=3, still one word/cycle sustained.
